// File: rtl/pipelined_tree_mult.sv
// Fully pipelined N x N adder-tree multiplier with valid/ready on both sides and per-stage bubble collapsing.
// Optional feature macro: TREE_MULT_TAG_EN adds an in_tag/out_tag sideband that travels with each beat.
module pipelined_tree_mult #(
    parameter int N = 16
`ifdef TREE_MULT_TAG_EN
    ,
    parameter int TAG_W = 4
`endif
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_a,
    input  logic [N-1:0]   in_b,
    input  logic           in_signed,
`ifdef TREE_MULT_TAG_EN
    input  logic [TAG_W-1:0] in_tag,
    output logic [TAG_W-1:0] out_tag,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_p,
    output logic           busy
);

    localparam int LEVELS = $clog2(N);
    localparam int W      = 2 * N;
    localparam int NODES  = N - 1;

    generate
        if (N < 4 || (N & (N - 1)) != 0) begin : g_bad_n
            $error("pipelined_tree_mult: N must be a power of 2 and >= 4");
        end
    endgenerate

    logic [N-1:0]    a_q;
    logic [N-1:0]    b_q;
    logic            sgn_q;
    logic [LEVELS:0] v_q;
    logic [LEVELS:0] rdy;
    logic [LEVELS:0] en;
    logic [W-1:0]    a_ext;
    logic [W-1:0]    pp      [N];
    // Tree nodes packed level after level: level l starts at N - (N >> l).
    logic [W-1:0]    node_q  [NODES];
    logic [W-1:0]    node_d  [NODES];
    logic [NODES-1:0] node_en;

    assign a_ext = sgn_q ? {{N{a_q[N-1]}}, a_q} : {{N{1'b0}}, a_q};

    genvar gi, gj;
    generate
        for (gi = 0; gi <= LEVELS; gi++) begin : g_ctl
            // A stage can take a beat unless it and every stage after it is full and the sink stalls.
            assign rdy[gi] = out_ready | ~(&v_q[LEVELS:gi]);
            if (gi == 0) begin : g_en0
                assign en[gi] = rdy[gi] & in_valid;
            end else begin : g_enk
                assign en[gi] = rdy[gi] & v_q[gi-1];
            end
        end

        for (gi = 0; gi < N; gi++) begin : g_pp
            if (gi == N - 1) begin : g_top
                // The sign bit of a two's-complement multiplier carries weight -2^(N-1).
                assign pp[gi] = !b_q[gi] ? '0 :
                                sgn_q ? (-(a_ext << gi)) : (a_ext << gi);
            end else begin : g_low
                assign pp[gi] = b_q[gi] ? (a_ext << gi) : '0;
            end
        end

        for (gi = 0; gi < LEVELS; gi++) begin : g_lvl
            localparam int BASE = N - (N >> gi);
            for (gj = 0; gj < (N >> (gi + 1)); gj++) begin : g_node
                if (gi == 0) begin : g_from_pp
                    assign node_d[BASE+gj] = pp[2*gj] + pp[2*gj+1];
                end else begin : g_from_lvl
                    localparam int PB = N - 2 * (N >> gi);
                    assign node_d[BASE+gj] = node_q[PB+2*gj] + node_q[PB+2*gj+1];
                end
                assign node_en[BASE+gj] = en[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            sgn_q <= 1'b0;
            for (int i = 0; i < NODES; i++) begin
                node_q[i] <= '0;
            end
        end else begin
            if (rdy[0]) begin
                v_q[0] <= in_valid;
            end
            for (int k = 1; k <= LEVELS; k++) begin
                if (rdy[k]) begin
                    v_q[k] <= v_q[k-1];
                end
            end
            if (en[0]) begin
                a_q   <= in_a;
                b_q   <= in_b;
                sgn_q <= in_signed;
            end
            for (int i = 0; i < NODES; i++) begin
                if (node_en[i]) begin
                    node_q[i] <= node_d[i];
                end
            end
        end
    end

`ifdef TREE_MULT_TAG_EN
    logic [TAG_W-1:0] tag_q [LEVELS+1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= LEVELS; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            if (en[0]) begin
                tag_q[0] <= in_tag;
            end
            for (int k = 1; k <= LEVELS; k++) begin
                if (en[k]) begin
                    tag_q[k] <= tag_q[k-1];
                end
            end
        end
    end

    assign out_tag = tag_q[LEVELS];
`endif

    assign in_ready  = rdy[0];
    assign out_valid = v_q[LEVELS];
    assign out_p     = node_q[NODES-1];
    assign busy      = |v_q;

endmodule
